// File: rtl/mem_pkg.sv
// Shared constants, state type and funct3 decode helpers for the memory-stage load/store unit.
package mem_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } mem_state_t;

    // Unsigned load encodings have no store counterpart.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Load writeback formatter: selects the addressed byte/halfword of a raw word and extends it.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, then sign/zero extension by access type
    always_comb begin
        byte_s   = 8'h00;
        half_s   = 16'h0000;
        result_o = raw_i;
        case (off_i)
            2'd0:    byte_s = raw_i[7:0];
            2'd1:    byte_s = raw_i[15:8];
            2'd2:    byte_s = raw_i[23:16];
            2'd3:    byte_s = raw_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off_i[1]) begin
            half_s = raw_i[31:16];
        end else begin
            half_s = raw_i[15:0];
        end
        case (funct3_i)
            F3_B:    result_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   result_o = {24'h000000, byte_s};
            F3_H:    result_o = {{16{half_s[15]}}, half_s};
            F3_HU:   result_o = {16'h0000, half_s};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit driving a valid/grant data port and stalling the pipeline until done.
// Build option MISALIGN_TRAP_EN: misaligned halfword/word accesses are dropped and flagged on MisalignM.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [NUM_LANES-1:0]  mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM
);

    mem_state_t            state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [NUM_LANES-1:0]  mem_wstrb_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;

    logic                  is_store_s;
    logic                  req_ok_s;
    logic                  misalign_s;
    logic                  access_s;
    logic [1:0]            off_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [DATA_WIDTH-1:0] fmt_s;
    logic [NUM_LANES-1:0]  wstrb_s;

    assign is_store_s = MemWriteM;
    assign off_s      = ALUResultM[1:0];
    assign req_ok_s   = ValidM & (MemReadM | MemWriteM) & f3_legal(is_store_s, funct3M);

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = req_ok_s & f3_misaligned(funct3M, off_s);
`else
    assign misalign_s = 1'b0;
`endif

    assign access_s = req_ok_s & ~misalign_s;
    assign StallM   = rst_n & access_s & (state_q != DONE);

    // Store data replication and byte-enable placement
    always_comb begin
        wdata_s = WriteDataM;
        wstrb_s = 4'b0000;
        if (is_store_s) begin
            case (funct3M)
                F3_B: begin
                    wdata_s = {4{WriteDataM[7:0]}};
                    wstrb_s = 4'b0001 << off_s;
                end
                F3_H: begin
                    wdata_s = {2{WriteDataM[15:0]}};
                    wstrb_s = 4'b0011 << {off_s[1], 1'b0};
                end
                default: begin
                    wdata_s = WriteDataM;
                    wstrb_s = 4'b1111;
                end
            endcase
        end else begin
            wstrb_s = 4'b0000;
        end
    end

    load_formatter u_load_formatter (
        .raw_i    (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (fmt_s)
    );

    // Access sequencer; request fields are captured once and held until grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            read_data_q <= 32'h0000_0000;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_s) begin
                        state_q     <= REQ;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store_s;
                        mem_addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= wdata_s;
                        mem_wstrb_q <= wstrb_s;
                        f3_q        <= funct3M;
                        off_q       <= off_s;
                    end else begin
                        misalign_q <= misalign_s;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_we_q ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        read_data_q <= fmt_s;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign ReadDataM = read_data_q;
    assign MisalignM = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses against a reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [31:0] rd_model = 32'h0000_0000;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ValidM     (ValidM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference rules
    function automatic bit m_legal(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        logic [2:0] t;
        t = f3;
        return 1 << t[1:0];
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
        int          size, off;
        logic [31:0] v;
        logic [2:0]  t;
        t    = f3;
        size = m_size(f3);
        off  = int'(a % 4);
        if (size == 4) return raw;
        off = off - (off % size);
        v   = (raw >> (8 * off)) & ((32'd1 << (8 * size)) - 32'd1);
        if (!t[2] && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int size, off;
        size = m_size(f3);
        off  = int'(a % 4);
        return ((32'd1 << size) - 32'd1) << (off - (off % size));
    endfunction

    // One instruction in MEM, with a memory that grants after g idle request cycles
    // and returns read data r cycles after the grant.
    task automatic run_access(input bit vld, input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input int g, input int r, input logic [31:0] raw);
        bit acc, mis, granted, rv_done, done;
        int exp_stall, stalls, req_cycles, since;
        acc        = vld && (rd || wr) && m_legal(wr, f3);
        mis        = acc && m_misaligned(f3, a);
        exp_stall  = (acc && !mis) ? (wr ? 2 + g : 2 + g + r) : 0;
        granted    = 1'b0;
        rv_done    = 1'b0;
        done       = 1'b0;
        stalls     = 0;
        req_cycles = 0;
        since      = 0;
        @(negedge clk);
        ValidM = vld; MemReadM = rd; MemWriteM = wr; funct3M = f3;
        ALUResultM = a; WriteDataM = d;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (granted) check_val("req_drop", {31'd0, mem_req}, 32'd0);
            if (mem_req && !granted) begin
                check_val("addr", mem_addr, a & ~32'd3);
                check_val("we", {31'd0, mem_we}, {31'd0, wr});
                if (wr) begin
                    check_val("wdata", mem_wdata, m_wdata(f3, d));
                    check_val("wstrb", {28'd0, mem_wstrb}, m_wstrb(f3, a));
                end
                if (req_cycles == g) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                end else begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
                req_cycles++;
            end else if (granted && !wr && !rv_done) begin
                since++;
                if (since == r) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = raw;
                    rv_done    = 1'b1;
                end
            end
            #1;
            if (StallM) stalls++;
            else done = 1'b1;
        end
        if (!done) check_val("stall_timeout", 32'd0, 32'd1);
        check_val("stall_cycles", stalls, exp_stall);
        if (acc && !mis && !wr) rd_model = m_load(f3, a, raw);
        check_val("rdata", ReadDataM, rd_model);
        // Two quiet cycles with a stray response that must be ignored
        @(negedge clk);
        ValidM = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        check_val("misalign", {31'd0, MisalignM}, {31'd0, mis});
        check_val("idle_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("misalign_pulse", {31'd0, MisalignM}, 32'd0);
        check_val("rdata_hold", ReadDataM, rd_model);
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = F3_W;
        ALUResultM = 32'h0000_0400; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("rst_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_val("rst_wait_stall", {31'd0, StallM}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_stall_forced", {31'd0, StallM}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ValidM = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        check_val("rst_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("rst_rdata", ReadDataM, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("rst_late_rsp", ReadDataM, 32'd0);
        check_val("rst_late_req", {31'd0, mem_req}, 32'd0);
        rd_model = 32'h0000_0000;
    endtask

    task automatic run_random(input int n);
        bit         vld;
        logic [1:0] rw;
        logic [2:0] f3;
        for (int i = 0; i < n; i++) begin
            vld = ($urandom_range(0, 9) != 0);
            rw  = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            run_access(vld, rw[0], rw[1], f3, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        funct3M = 3'b000; ALUResultM = 32'd0; WriteDataM = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_val("rst_readdata", ReadDataM, 32'd0);
        check_val("rst_misalign", {31'd0, MisalignM}, 32'd0);
        check_val("rst_stall", {31'd0, StallM}, 32'd0);

        run_access(1'b1, 1'b0, 1'b1, F3_B,  32'h0000_0103, 32'h0000_00A5, 0, 1, 32'd0);
        run_access(1'b1, 1'b1, 1'b0, F3_B,  32'h0000_0102, 32'd0, 0, 1, 32'h0080_FF00);
        run_access(1'b1, 1'b1, 1'b0, F3_BU, 32'h0000_0102, 32'd0, 0, 1, 32'h0080_FF00);
        run_access(1'b1, 1'b1, 1'b0, F3_H,  32'h0000_0202, 32'd0, 0, 1, 32'h8001_1234);
        run_access(1'b1, 1'b1, 1'b0, F3_HU, 32'h0000_0202, 32'd0, 0, 1, 32'h8001_1234);
        run_access(1'b1, 1'b1, 1'b0, F3_W,  32'h0000_0300, 32'd0, 2, 2, 32'hCAFE_F00D);
        run_access(1'b1, 1'b1, 1'b1, F3_H,  32'h0000_0206, 32'h1234_ABCD, 1, 1, 32'd0);
        run_access(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'd0, 0, 1, 32'h1111_1111);
        run_access(1'b1, 1'b0, 1'b1, F3_BU, 32'h0000_0300, 32'h5555_5555, 0, 1, 32'd0);
        reset_mid_wait();
        run_access(1'b1, 1'b1, 1'b0, F3_W,  32'h0000_0101, 32'd0, 0, 1, 32'h7654_3210);
        run_access(1'b1, 1'b0, 1'b1, F3_W,  32'h0000_0102, 32'hA1B2_C3D4, 0, 1, 32'd0);
        run_random(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
